mem_rr_arbiter: RTL and testbench

- Sequencer and arbiter that shares one memory port (addr/data/write/write_size/valid handshake) between N_ACCESSORS requesters, e.g. core fetch, core LSU and cache.
- Grants are round-robin; each grant is one complete memory transaction with a one-cycle done pulse back to the winner.
- Sits between the accessors and the memory model, in place of direct accessor-to-memory wiring.

---
 rtl/mem_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// Round-robin sequencer sharing one memory port between N_ACCESSORS requesters.
// Optional abort on unresponsive memory: define MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
    parameter int BITSIZE        = 32,
    parameter int N_ACCESSORS    = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           reset_i,
    input  logic [32*N_ACCESSORS-1:0]      acc_address_i,
    input  logic [N_ACCESSORS-1:0]         acc_write_i,
    input  logic [2*N_ACCESSORS-1:0]       acc_write_size_i,
    input  logic [N_ACCESSORS-1:0]         acc_read_i,
    input  logic [BITSIZE*N_ACCESSORS-1:0] acc_data_i,
    output logic [BITSIZE*N_ACCESSORS-1:0] acc_data_o,
    output logic [N_ACCESSORS-1:0]         acc_done_o,
    output logic [N_ACCESSORS-1:0]         acc_err_o,
    output logic [31:0]                    mem_addr_o,
    output logic [BITSIZE-1:0]             mem_data_o,
    output logic                           mem_write_o,
    output logic [1:0]                     mem_write_size_o,
    output logic                           mem_valid_o,
    input  logic [BITSIZE-1:0]             mem_data_i,
    input  logic                           mem_valid_i
);

    localparam int          IW = (N_ACCESSORS > 1) ? $clog2(N_ACCESSORS) : 1;
    localparam int unsigned NA = N_ACCESSORS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t                           r_state;
    logic [IW-1:0]                    r_ptr;
    logic [IW-1:0]                    r_grant;
    logic [31:0]                      r_addr;
    logic [BITSIZE-1:0]               r_wdata;
    logic                             r_write;
    logic [1:0]                       r_size;
    logic                             r_mem_valid;
    logic [BITSIZE*N_ACCESSORS-1:0]   r_rdata;
    logic [N_ACCESSORS-1:0]           r_done;
    logic [N_ACCESSORS-1:0]           r_err;

    logic [N_ACCESSORS-1:0]           w_req;
    logic                             w_found;
    logic [IW-1:0]                    w_pick;
    logic [IW-1:0]                    w_cand;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CLOG_TO = $clog2(TIMEOUT_CYCLES);
    localparam int CW      = (CLOG_TO < 8) ? 8 : ((CLOG_TO > 16) ? 16 : CLOG_TO);
    logic [CW-1:0] r_cnt;
`endif

    assign w_req = acc_read_i | acc_write_i;

    // First requester found scanning upward from the slot after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NA; k++) begin
            w_cand = IW'((32'(r_ptr) + k) % NA);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IW'(N_ACCESSORS - 1);
            r_grant     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_size      <= '0;
            r_mem_valid <= 1'b0;
            r_rdata     <= '0;
            r_done      <= '0;
            r_err       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_pick;
                        r_ptr       <= w_pick;
                        r_addr      <= acc_address_i[32*w_pick +: 32];
                        r_wdata     <= acc_data_i[BITSIZE*w_pick +: BITSIZE];
                        r_write     <= acc_write_i[w_pick];
                        r_size      <= acc_write_size_i[2*w_pick +: 2];
                        r_mem_valid <= 1'b1;
                        r_state     <= ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (mem_valid_i) begin
                        if (!r_write) begin
                            r_rdata[BITSIZE*r_grant +: BITSIZE] <= mem_data_i;
                        end
                        r_done[r_grant] <= 1'b1;
                        r_mem_valid     <= 1'b0;
                        r_state         <= ST_DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // A response arriving on the expiry cycle takes priority over the abort.
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_done[r_grant] <= 1'b1;
                        r_err[r_grant]  <= 1'b1;
                        r_mem_valid     <= 1'b0;
                        r_state         <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign acc_data_o       = r_rdata;
    assign acc_done_o       = r_done;
`ifdef MEM_ARB_TIMEOUT_EN
    assign acc_err_o        = r_err;
`else
    assign acc_err_o        = '0;
`endif
    assign mem_addr_o       = r_addr;
    assign mem_data_o       = r_wdata;
    assign mem_write_o      = r_write;
    assign mem_write_size_o = r_size;
    assign mem_valid_o      = r_mem_valid;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: randomized batches against a round-robin transaction model.
module tb_mem_rr_arbiter;

    localparam int N  = 3;
    localparam int BW = 32;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [32*N-1:0]   acc_address_i;
    logic [N-1:0]      acc_write_i;
    logic [2*N-1:0]    acc_write_size_i;
    logic [N-1:0]      acc_read_i;
    logic [BW*N-1:0]   acc_data_i;
    logic [BW*N-1:0]   acc_data_o;
    logic [N-1:0]      acc_done_o;
    logic [N-1:0]      acc_err_o;
    logic [31:0]       mem_addr_o;
    logic [BW-1:0]     mem_data_o;
    logic              mem_write_o;
    logic [1:0]        mem_write_size_o;
    logic              mem_valid_o;
    logic [BW-1:0]     mem_data_i;
    logic              mem_valid_i;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .BITSIZE        (BW),
        .N_ACCESSORS    (N),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk              (clk),
        .reset_i          (reset_i),
        .acc_address_i    (acc_address_i),
        .acc_write_i      (acc_write_i),
        .acc_write_size_i (acc_write_size_i),
        .acc_read_i       (acc_read_i),
        .acc_data_i       (acc_data_i),
        .acc_data_o       (acc_data_o),
        .acc_done_o       (acc_done_o),
        .acc_err_o        (acc_err_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_write_o      (mem_write_o),
        .mem_write_size_o (mem_write_size_o),
        .mem_valid_o      (mem_valid_o),
        .mem_data_i       (mem_data_i),
        .mem_valid_i      (mem_valid_i)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [1:0]  size;
        int          issue_cyc;
    } txn_t;

    txn_t        bus_q[$];
    txn_t        done_q[$];
    logic [31:0] model_slot[N];
    int          last_grant;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_done_cyc = 0;
    int          force_delay = -1;
    bit          mon_en = 1'b0;

    logic [31:0] t_addr[N];
    logic [31:0] t_data[N];
    int          t_op[N];      // 0 read, 1 write, 2 read+write
    logic [1:0]  t_size[N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory responder: answers after a per-transaction delay; noise on mem_valid_i outside requests.
    initial begin
        int  cnt;
        int  dly;
        bit  busy_seen;
        busy_seen   = 1'b0;
        cnt         = 0;
        dly         = 0;
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid_o) begin
                if (!busy_seen) begin
                    cnt       = 0;
                    dly       = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
                    busy_seen = 1'b1;
                end
                if (cnt == dly) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = mem_fn(mem_addr_o);
                end else begin
                    mem_valid_i = 1'b0;
                    mem_data_i  = $urandom;
                end
                cnt++;
            end else begin
                busy_seen   = 1'b0;
                mem_valid_i = 1'($urandom_range(0, 1));
                mem_data_i  = $urandom;
            end
        end
    end

    // Monitor: pops expected transactions when the DUT issues a request or a done pulse.
    initial begin
        bit          prev_valid;
        bit          prev_done;
        txn_t        e;
        txn_t        d;
        logic [31:0] cur_addr;
        logic [31:0] cur_data;
        logic [2:0]  cur_ctl;
        logic [N-1:0] expv;
        prev_valid = 1'b0;
        prev_done  = 1'b0;
        cur_addr   = '0;
        cur_data   = '0;
        cur_ctl    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (mem_valid_o && !prev_valid) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_request: got addr %0h expected no request", mem_addr_o);
                    end else begin
                        e = bus_q.pop_front();
                        check("mem_addr", mem_addr_o, e.addr);
                        check("mem_write", mem_write_o, e.wr);
                        check("mem_write_size", mem_write_size_o, e.size);
                        check("mem_data", mem_data_o, e.data);
                        if (e.issue_cyc >= 0)
                            check("req_to_valid_latency", cyc - e.issue_cyc, 1);
                        else
                            check("done_to_next_valid", cyc - last_done_cyc, 2);
                    end
                    cur_addr = mem_addr_o;
                    cur_data = mem_data_o;
                    cur_ctl  = {mem_write_o, mem_write_size_o};
                end else if (mem_valid_o) begin
                    check("busy_addr_stable", mem_addr_o, cur_addr);
                    check("busy_data_stable", mem_data_o, cur_data);
                    check("busy_ctl_stable", {mem_write_o, mem_write_size_o}, cur_ctl);
                end
                if (acc_done_o != '0) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got %b expected none", acc_done_o);
                    end else begin
                        d = done_q.pop_front();
                        expv = '0;
                        expv[d.idx] = 1'b1;
                        check("done_vec", acc_done_o, expv);
                        check("err_vec", acc_err_o, 0);
                        check("done_phase", {prev_valid, mem_valid_o}, 2'b10);
                        check("done_single_pulse", prev_done, 0);
                        if (!d.wr) model_slot[d.idx] = mem_fn(d.addr);
                        for (int s = 0; s < N; s++)
                            check($sformatf("slot%0d_data", s), acc_data_o[BW*s +: BW], model_slot[s]);
                    end
                    last_done_cyc = cyc;
                end
            end
            prev_valid = mem_valid_o;
            prev_done  = (acc_done_o != '0);
        end
    end

    // Issue the masked requests together; the model orders them round-robin after the last grant.
    task automatic run_batch(input logic [N-1:0] mask);
        txn_t         e;
        int           base;
        int           pos;
        bit           first;
        logic [N-1:0] pending;
        int           budget;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                acc_address_i[32*i +: 32]   = t_addr[i];
                acc_data_i[BW*i +: BW]      = t_data[i];
                acc_write_size_i[2*i +: 2]  = t_size[i];
                acc_read_i[i]               = (t_op[i] != 1);
                acc_write_i[i]              = (t_op[i] != 0);
            end
        end
        base  = last_grant;
        first = 1'b1;
        for (int k = 1; k <= N; k++) begin
            pos = (base + k) % N;
            if (mask[pos]) begin
                e.idx       = pos;
                e.addr      = t_addr[pos];
                e.data      = t_data[pos];
                e.wr        = (t_op[pos] != 0);
                e.size      = t_size[pos];
                e.issue_cyc = first ? cyc : -1;
                first       = 1'b0;
                bus_q.push_back(e);
                done_q.push_back(e);
                last_grant  = pos;
            end
        end
        pending = mask;
        budget  = 0;
        while (pending != '0 && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
            for (int i = 0; i < N; i++) begin
                if (pending[i] && acc_done_o[i]) begin
                    acc_read_i[i]  = 1'b0;
                    acc_write_i[i] = 1'b0;
                    pending[i]     = 1'b0;
                end
            end
        end
        if (pending != '0) check("batch_completion", pending, 0);
        acc_read_i  = '0;
        acc_write_i = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic [31:0] a, input logic [31:0] dt,
                              input int op, input logic [1:0] sz);
        t_addr[i] = a;
        t_data[i] = dt;
        t_op[i]   = op;
        t_size[i] = sz;
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++)
            set_fields(i, $urandom & 32'hFFFF_FFFC, $urandom, int'($urandom_range(0, 2)),
                       2'($urandom_range(0, 2)));
    endtask

    initial begin
        int waited;
        reset_i          = 1'b1;
        acc_address_i    = '0;
        acc_write_i      = '0;
        acc_write_size_i = '0;
        acc_read_i       = '0;
        acc_data_i       = '0;
        for (int i = 0; i < N; i++) model_slot[i] = '0;
        last_grant = N - 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_valid", mem_valid_o, 0);
        check("reset_done", acc_done_o, 0);
        check("reset_err", acc_err_o, 0);
        check("reset_mem_addr", mem_addr_o, 0);
        check("reset_mem_write", mem_write_o, 0);
        check("reset_data", acc_data_o, 0);
        reset_i = 1'b0;
        mon_en  = 1'b1;
        @(posedge clk);
        #1;

        // Single read from accessor 1 with a same-cycle memory response
        force_delay = 0;
        set_fields(1, 32'h0000_0100, 32'h0, 0, 2'b10);
        run_batch(3'b010);

        // Contention: everyone requests, twice in a row
        randomize_fields();
        run_batch(3'b111);
        randomize_fields();
        run_batch(3'b111);

        // Read+write together: the write wins and slot 2 keeps its value
        set_fields(2, 32'h0000_0040, 32'h1234_5678, 2, 2'b10);
        run_batch(3'b100);

        // Slow memory
        force_delay = 5;
        randomize_fields();
        run_batch(3'b001);
        randomize_fields();
        run_batch(3'b111);

        force_delay = -1;
        for (int b = 0; b < 40; b++) begin
            randomize_fields();
            run_batch(3'($urandom_range(1, 7)));
        end

        // Reset while BUSY abandons the transaction and restarts arbitration at accessor 0
        force_delay = 20;
        mon_en      = 1'b0;
        acc_address_i[32 +: 32] = 32'h0000_0200;
        acc_read_i[1]           = 1'b1;
        waited = 0;
        while (!mem_valid_o && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("reset_test_busy", mem_valid_o, 1);
        @(posedge clk);
        #1;
        reset_i     = 1'b1;
        acc_read_i  = '0;
        acc_write_i = '0;
        @(posedge clk);
        #1;
        check("midreset_mem_valid", mem_valid_o, 0);
        check("midreset_done", acc_done_o, 0);
        check("midreset_data", acc_data_o, 0);
        reset_i = 1'b0;
        bus_q.delete();
        done_q.delete();
        for (int i = 0; i < N; i++) model_slot[i] = '0;
        last_grant  = N - 1;
        force_delay = -1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("postreset_no_done", acc_done_o, 0);
        end
        mon_en = 1'b1;
        for (int i = 0; i < N; i++) set_fields(i, $urandom & 32'hFFFF_FFFC, $urandom, 0, 2'b00);
        run_batch(3'b111);
        randomize_fields();
        run_batch(3'b111);

        check("queues_drained", bus_q.size() + done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
